// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: widths, atan table in turns, gain, FSM states.
package cordic_pkg;

  localparam int WIDTH     = 32;
  localparam int FRAC_BITS = 29;
  localparam int IWIDTH    = 34;
  localparam int LUT_DEPTH = 21;

  // round(0.6072529350 * 2^29), inverse of the accumulated CORDIC gain
  localparam logic signed [WIDTH-1:0] K_GAIN    = 32'sh136E_9DB5;
  localparam logic signed [WIDTH-1:0] HALF_TURN = 32'sh1000_0000;

  // atan(2^-i) in turns, Q3.29 (0.125 turn = 0x0400_0000)
  localparam logic [WIDTH-1:0] ATAN_LUT [0:LUT_DEPTH-1] = '{
    32'h0400_0000, 32'h025C_80A4, 32'h013F_670B, 32'h00A2_223B,
    32'h0051_61A8, 32'h0028_BAFC, 32'h0014_5EC4, 32'h000A_2F8B,
    32'h0005_17CA, 32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2F9,
    32'h0000_517D, 32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30,
    32'h0000_0518, 32'h0000_028C, 32'h0000_0146, 32'h0000_00A3,
    32'h0000_0051
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_SCALE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Indices past the table contribute no rotation angle.
  function automatic logic signed [WIDTH-1:0] atan_lookup(input logic [4:0] idx);
    if (idx < 5'(LUT_DEPTH)) return signed'(ATAN_LUT[idx]);
    else                     return '0;
  endfunction

endpackage

// File: rtl/cordic_vectoring_stage.sv
// One combinational vectoring micro-rotation: steer y toward zero.
module cordic_vectoring_stage
  import cordic_pkg::*;
(
  input  logic signed [IWIDTH-1:0] i_x,
  input  logic signed [IWIDTH-1:0] i_y,
  input  logic signed [WIDTH-1:0]  i_z,
  input  logic [4:0]               i_iter,
  output logic signed [IWIDTH-1:0] o_x,
  output logic signed [IWIDTH-1:0] o_y,
  output logic signed [WIDTH-1:0]  o_z
);

  logic signed [IWIDTH-1:0] w_x_sh;
  logic signed [IWIDTH-1:0] w_y_sh;
  logic signed [WIDTH-1:0]  w_atan;
  logic                     w_y_neg;

  assign w_x_sh  = i_x >>> i_iter;
  assign w_y_sh  = i_y >>> i_iter;
  assign w_atan  = atan_lookup(i_iter);
  assign w_y_neg = i_y[IWIDTH-1];

  // Both x and y updates read the pre-update values.
  assign o_x = w_y_neg ? (i_x - w_y_sh) : (i_x + w_y_sh);
  assign o_y = w_y_neg ? (i_y + w_x_sh) : (i_y - w_x_sh);
  assign o_z = w_y_neg ? (i_z - w_atan) : (i_z + w_atan);

endmodule

// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring CORDIC: (x, y) -> (magnitude, atan2 in turns).
//
// state    | meaning
// ST_IDLE  | in_ready high, waiting for an input vector
// ST_ITER  | one micro-rotation per cycle, i = 0 .. ITERATIONS-1
// ST_SCALE | gain compensation and saturation of the magnitude
// ST_DONE  | out_valid high, outputs held until out_ready
module cordic_vectoring_iter
  import cordic_pkg::*;
#(
  parameter int ITERATIONS = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mag_out,
  output logic [WIDTH-1:0] ang_out
);

  localparam logic [4:0] ITER_LAST = 5'(ITERATIONS - 1);

  state_t                   r_state;
  logic signed [IWIDTH-1:0] r_x;
  logic signed [IWIDTH-1:0] r_y;
  logic signed [WIDTH-1:0]  r_z;
  logic [4:0]               r_iter;
  logic                     r_zero;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic [WIDTH-1:0]         r_mag;
  logic [WIDTH-1:0]         r_ang;

  logic signed [IWIDTH-1:0] w_x_ext;
  logic signed [IWIDTH-1:0] w_y_ext;
  logic signed [IWIDTH-1:0] w_x_nxt;
  logic signed [IWIDTH-1:0] w_y_nxt;
  logic signed [WIDTH-1:0]  w_z_nxt;
  logic signed [65:0]       w_prod;
  logic signed [65:0]       w_scaled;
  logic [WIDTH-1:0]         w_mag_sat;

  assign w_x_ext = {{2{x_in[WIDTH-1]}}, x_in};
  assign w_y_ext = {{2{y_in[WIDTH-1]}}, y_in};

  cordic_vectoring_stage u_stage (
    .i_x    (r_x),
    .i_y    (r_y),
    .i_z    (r_z),
    .i_iter (r_iter),
    .o_x    (w_x_nxt),
    .o_y    (w_y_nxt),
    .o_z    (w_z_nxt)
  );

  // Floor of x*K / 2^29; anything above the positive Q3.29 range clips.
  assign w_prod   = 66'(r_x) * 66'(K_GAIN);
  assign w_scaled = w_prod >>> FRAC_BITS;
  assign w_mag_sat = w_scaled[65]             ? '0 :
                     (|w_scaled[64:WIDTH-1])  ? 32'h7FFF_FFFF :
                                                {1'b0, w_scaled[WIDTH-2:0]};

  // Sequencing FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_iter      <= '0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_mag       <= '0;
      r_ang       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            // Fold the left half-plane onto the right one and seed z with ±0.5 turn.
            if (x_in[WIDTH-1]) begin
              r_x <= -w_x_ext;
              r_y <= -w_y_ext;
              r_z <= y_in[WIDTH-1] ? -HALF_TURN : HALF_TURN;
            end else begin
              r_x <= w_x_ext;
              r_y <= w_y_ext;
              r_z <= '0;
            end
            r_zero     <= (x_in == '0) && (y_in == '0);
            r_iter     <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_ITER;
          end
        end
        ST_ITER: begin
          r_x    <= w_x_nxt;
          r_y    <= w_y_nxt;
          r_z    <= w_z_nxt;
          r_iter <= r_iter + 5'd1;
          if (r_iter == ITER_LAST) r_state <= ST_SCALE;
        end
        ST_SCALE: begin
          r_mag       <= r_zero ? '0 : w_mag_sat;
          r_ang       <= r_zero ? '0 : r_z;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign mag_out   = r_mag;
  assign ang_out   = r_ang;

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// Directed bench for the iterative vectoring CORDIC.
module tb_cordic_vectoring_iter;

  localparam int LAT_EXP   = 22;
  localparam int LAT_BOUND = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_in;
  logic [31:0] y_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] mag_out;
  logic [31:0] ang_out;

  int n_checks = 0;
  int n_fail   = 0;

  cordic_vectoring_iter #(.ITERATIONS(21)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mag_out   (mag_out),
    .ang_out   (ang_out)
  );

  always #5 clk = ~clk;

  // Signed comparison within a tolerance in LSBs.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v,
                     input int tol = 0);
    longint d;
    d = longint'($signed(obs)) - longint'($signed(exp_v));
    if (d < 0) d = -d;
    n_checks++;
    if (d > longint'(tol)) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (tol %0d)", tag, obs, exp_v, tol);
    end
  endtask

  // Send one vector, measure latency, check results; release if out_ready is high.
  task automatic run_vec(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] em, input logic [31:0] ea,
                         input int tol_m, input int tol_a);
    int lat;
    @(negedge clk);
    chk({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
    x_in = x; y_in = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_busy"}, {31'b0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < LAT_BOUND) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, LAT_EXP);
    chk({tag, "_mag"}, mag_out, em, tol_m);
    chk({tag, "_ang"}, ang_out, ea, tol_a);
    if (out_ready) begin
      @(posedge clk); #1;
      chk({tag, "_ovld_clr"}, {31'b0, out_valid}, 32'd0);
      chk({tag, "_rdy_back"}, {31'b0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x_in = '0; y_in = '0;
    #3;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mag", mag_out, 32'd0);
    chk("rst_ang", ang_out, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_vec("pos_x",  32'h2000_0000, 32'h0000_0000, 32'h2000_0000, 32'h0000_0000, 128, 128);
    run_vec("pos_y",  32'h0000_0000, 32'h2000_0000, 32'h2000_0000, 32'h0800_0000, 128, 128);
    run_vec("neg_x",  32'hE000_0000, 32'h0000_0000, 32'h2000_0000, 32'h1000_0000, 128, 128);
    // (-1,-1): magnitude sqrt(2), angle -0.375 turn
    run_vec("neg_xy", 32'hE000_0000, 32'hE000_0000, 32'h2D41_3CCD, 32'hF400_0000, 128, 128);
    run_vec("zero",   32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 0);
    run_vec("sat",    32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0400_0000, 0, 128);

    // Backpressure: (0.5,-0.5) -> sqrt(0.5), -0.125 turn, held for 10 cycles
    out_ready = 1'b0;
    run_vec("stall", 32'h1000_0000, 32'hF000_0000, 32'h16A0_9E66, 32'hFC00_0000, 128, 128);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 3) begin in_valid = 1'b1; x_in = 32'h2000_0000; y_in = 32'h0; end
      if (k == 5) in_valid = 1'b0;
      @(posedge clk); #1;
      chk("stall_ovld", {31'b0, out_valid}, 32'd1);
      chk("stall_rdy", {31'b0, in_ready}, 32'd0);
      chk("stall_mag", mag_out, 32'h16A0_9E66, 128);
      chk("stall_ang", ang_out, 32'hFC00_0000, 128);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rel_ovld", {31'b0, out_valid}, 32'd0);
    chk("rel_rdy", {31'b0, in_ready}, 32'd1);
    chk("rel_mag_hold", mag_out, 32'h16A0_9E66, 128);
    chk("rel_ang_hold", ang_out, 32'hFC00_0000, 128);
    repeat (2) @(posedge clk);
    #1;
    chk("stall_pulse_ignored", {31'b0, in_ready}, 32'd1);

    // Reset in the middle of an operation
    @(negedge clk);
    x_in = 32'h2000_0000; y_in = 32'h2000_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_rdy", {31'b0, in_ready}, 32'd1);
    chk("abort_ovld", {31'b0, out_valid}, 32'd0);
    chk("abort_mag", mag_out, 32'd0);
    chk("abort_ang", ang_out, 32'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_valid", seen, 0);
    run_vec("post_rst", 32'h2000_0000, 32'h0000_0000, 32'h2000_0000, 32'h0000_0000, 128, 128);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
